// File: rtl/sar_search_controller_pkg.sv
// Shared types and helpers for the successive-approximation search controller.
// Default width matches the team's 4-bit magnitude comparator.
package sar_search_controller_pkg;

  localparam int unsigned SAR_WIDTH = 4;
  localparam logic [SAR_WIDTH-1:0] SAR_MSB_INIT = {1'b1, {(SAR_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TEST = 2'd1,
    DONE = 2'd2
  } sar_state_e;

  // A well-formed comparator response has exactly one flag set.
  function automatic logic onehot3(input logic less, input logic equal, input logic greater);
    return ( less & ~equal & ~greater) |
           (~less &  equal & ~greater) |
           (~less & ~equal &  greater);
  endfunction

endpackage

// File: rtl/sar_search_controller.sv
// Successive-approximation search: drives trial values into a magnitude
// comparator and resolves one bit per clock, stopping early on an exact match.
module sar_search_controller
  import sar_search_controller_pkg::*;
#(
  parameter int unsigned WIDTH = SAR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             less,
  input  logic             equal,
  input  logic             greater,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             exact,
  output logic             fault
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] TOP_IDX  = IDX_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB_INIT = {1'b1, {(WIDTH-1){1'b0}}};

  sar_state_e state_q, state_d;

  logic [WIDTH-1:0] trial_q,  trial_d;
  logic [IDX_W-1:0] idx_q,    idx_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exact_q,  exact_d;
  logic             fault_q,  fault_d;

  logic             flags_ok;
  logic [WIDTH-1:0] decided;

  assign flags_ok = onehot3(less, equal, greater);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = TEST;
        end
      end
      TEST: begin
        if (!flags_ok || equal || (idx_q == '0)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      trial_q  <= '0;
      idx_q    <= '0;
      result_q <= '0;
      exact_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      trial_q  <= trial_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      exact_q  <= exact_d;
      fault_q  <= fault_d;
    end
  end

  // Bit decision: "less" means the trial overshot, so the bit under test is dropped.
  always_comb begin
    decided = trial_q;
    if (less) begin
      decided[idx_q] = 1'b0;
    end
  end

  always_comb begin
    trial_d  = trial_q;
    idx_d    = idx_q;
    result_d = result_q;
    exact_d  = exact_q;
    fault_d  = fault_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          trial_d = MSB_INIT;
          idx_d   = TOP_IDX;
          exact_d = 1'b0;
          fault_d = 1'b0;
        end
      end
      TEST: begin
        if (!flags_ok) begin
          fault_d  = 1'b1;
          result_d = trial_q;
          trial_d  = '0;
        end else if (equal) begin
          exact_d  = 1'b1;
          result_d = trial_q;
          trial_d  = '0;
        end else if (idx_q == '0) begin
          result_d = decided;
          trial_d  = '0;
        end else begin
          trial_d                 = decided;
          trial_d[idx_q - 1'b1]   = 1'b1;
          idx_d                   = idx_q - 1'b1;
        end
      end
      DONE: begin
        trial_d = '0;
      end
      default: begin
        trial_d = '0;
      end
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state_q == TEST);
    done = (state_q == DONE);
  end

  assign trial  = trial_q;
  assign result = result_q;
  assign exact  = exact_q;
  assign fault  = fault_q;

endmodule
